bch_frame_arbiter: RTL and testbench
====================================

# bch_frame_arbiter

- Round-robin arbiter that shares one BCH encoder between two bit-serial input FIFOs.
- Grants the encoder's FIFO-read interface to one requester for exactly K data bits, one full codeword payload.
- Switches requesters only at frame boundaries, so codewords never mix sources.
- Sits between the two input FIFOs (read latency 1, standard mode) and the BCH encoder's FIFO_IN port; emits frame tags for downstream channel demultiplexing.

## Interface

Parameters:
- K, 7, payload bits per codeword; must be ≥ 2.
- CNT_W, 8, frame bit-counter width; requires 2^CNT_W > K.

Ports:
- CLK, in, 1: single clock, rising edge.
- RESET, in, 1: asynchronous, active-low.
- ENABLE, in, 1: permits new grants. Deasserting it never aborts a frame in progress.
- FIFO0_IN_DATA, in, 1: requester 0 FIFO dout.
- FIFO0_IN_EMPTY, in, 1: requester 0 FIFO empty.
- FIFO0_IN_RE, out, 1: requester 0 FIFO rd_en.
- FIFO1_IN_DATA, FIFO1_IN_EMPTY, FIFO1_IN_RE: same three signals for requester 1.
- ENC_DATA, out, 1: bit presented to the encoder FIFO_IN_DATA.
- ENC_EMPTY, out, 1: empty flag presented to the encoder.
- ENC_RE, in, 1: read enable from the encoder.
- GRANT, out, 1: current or most recent owner (0 or 1).
- BUSY, out, 1: a frame is locked.
- FRAME_START, out, 1: one-cycle pulse when a frame is granted.
- FRAME_DONE, out, 1: one-cycle pulse coincident with the last data bit on ENC_DATA.

## Operation

- FSM has two states: IDLE and LOCKED.
- IDLE:
  - ENC_EMPTY = 1; both FIFOx_IN_RE = 0.
  - If ENABLE = 1 and at least one FIFO is non-empty, grant and go to LOCKED; GRANT and BUSY update, FRAME_START pulses.
  - Round-robin: the requester other than the last owner wins ties. After reset, requester 0 has priority.
  - If only one FIFO is non-empty, that requester is granted.
- LOCKED:
  - ENC_EMPTY = FIFO_owner_EMPTY.
  - FIFO_owner_IN_RE = ENC_RE & ~FIFO_owner_EMPTY. The non-owner's RE stays 0.
  - An accepted read is ENC_RE & ~ENC_EMPTY; each one increments the bit counter.
  - On the accepted read with counter = K-1: counter clears, the last owner is recorded, and the FSM returns to IDLE.
- Owner FIFO empty mid-frame: the grant is held and ENC_EMPTY = 1. No switch occurs, even if the other FIFO is non-empty.
- ENC_RE while ENC_EMPTY = 1 has no effect: no RE, no count.
- ENC_DATA mux select is the grant delayed one cycle (sel_q), matching the FIFO read latency. The last bit of a frame therefore still comes from the correct source after the FSM returns to IDLE.
- RESET asserted mid-frame: the partial frame is abandoned, counter and round-robin pointer clear, and all outputs go to reset values.

## Timing

- Reset values:
  - GRANT = 0, BUSY = 0, FRAME_START = 0, FRAME_DONE = 0.
  - ENC_EMPTY = 1, ENC_DATA = 0, FIFO0_IN_RE = 0, FIFO1_IN_RE = 0.
  - Counter = 0, sel_q = 0.
- Grant latency: 1 cycle from a non-empty FIFO in IDLE to BUSY = 1 / FRAME_START = 1. ENC_EMPTY can drop in that same cycle.
- RE paths (ENC_RE → FIFOx_IN_RE, FIFOx_IN_EMPTY → ENC_EMPTY) are combinational, 0 cycles.
- Read data: ENC_DATA is valid 1 cycle after the accepted read.
- FRAME_DONE is registered and asserts the cycle after the K-th accepted read; in that cycle BUSY = 0.
- Minimum frame-to-frame gap: 1 IDLE cycle with ENC_EMPTY = 1. Back-to-back, a frame occupies K+1 cycles.

## Test plan

1. K=7; FIFO0 holds 14 bits, FIFO1 empty; ENC_RE=1 continuously.
   - Two frames, both GRANT=0; FRAME_START ×2, FRAME_DONE ×2.
   - Exactly 7 FIFO0_IN_RE pulses per frame; ENC_DATA bit order equals write order.
2. Both FIFOs hold 14 bits → GRANT sequence 0,1,0,1. Each frame takes exactly 7 reads; FIFO1_IN_RE is never high while GRANT=0.
3. FIFO0 empties after 3 bits while FIFO1 is non-empty:
   - GRANT stays 0, BUSY=1, ENC_EMPTY=1, FIFO1_IN_RE=0.
   - After FIFO0 is refilled, 4 more reads occur, then FRAME_DONE; the next grant goes to 1.
4. ENABLE driven low after 2 bits of a frame → the frame completes its 7 bits. No FRAME_START until ENABLE=1, then a grant in the next cycle.
5. RESET pulsed low after 4 bits of a frame granted to FIFO1:
   - All outputs take reset values immediately.
   - After release, with both FIFOs non-empty, GRANT=0 and a full 7-bit frame follows.
6. ENC_RE=1 in IDLE, and in LOCKED with the owner FIFO empty → no FIFOx_IN_RE pulse, and the frame still ends after exactly 7 accepted reads.

Source files
------------

// File: rtl/bch_frame_arbiter_if.sv
// Bundle of the arbiter's FIFO-side, encoder-side and status signals.
// master: the arbiter itself; slave: the surrounding FIFOs, encoder and control.
interface bch_frame_arbiter_if;
  logic enable;
  logic fifo0_in_data;
  logic fifo0_in_empty;
  logic fifo0_in_re;
  logic fifo1_in_data;
  logic fifo1_in_empty;
  logic fifo1_in_re;
  logic enc_data;
  logic enc_empty;
  logic enc_re;
  logic grant;
  logic busy;
  logic frame_start;
  logic frame_done;

  modport master (
    input  enable,
    input  fifo0_in_data,
    input  fifo0_in_empty,
    output fifo0_in_re,
    input  fifo1_in_data,
    input  fifo1_in_empty,
    output fifo1_in_re,
    output enc_data,
    output enc_empty,
    input  enc_re,
    output grant,
    output busy,
    output frame_start,
    output frame_done
  );

  modport slave (
    output enable,
    output fifo0_in_data,
    output fifo0_in_empty,
    input  fifo0_in_re,
    output fifo1_in_data,
    output fifo1_in_empty,
    input  fifo1_in_re,
    input  enc_data,
    input  enc_empty,
    output enc_re,
    input  grant,
    input  busy,
    input  frame_start,
    input  frame_done
  );
endinterface

// File: rtl/bch_frame_arbiter.sv
// Round-robin arbiter sharing one BCH encoder between two bit-serial FIFOs.
// A grant is held for exactly K accepted reads so codewords never mix sources.
module bch_frame_arbiter #(
  parameter int unsigned K     = 7,
  parameter int unsigned CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  bch_frame_arbiter_if.master bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             grant_q, grant_d;
  logic             prio_q, prio_d;      // requester preferred on a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q;
  logic             sel_q;               // grant delayed to line up with FIFO read latency
  logic             rd_q;                // a read was accepted last cycle, ENC_DATA is live

  logic locked, owner_empty, accept, last_bit;

  // Read-acceptance decode for the current owner.
  always_comb begin
    locked      = (state_q == LOCKED);
    owner_empty = grant_q ? bus.fifo1_in_empty : bus.fifo0_in_empty;
    accept      = bus.enc_re & locked & ~owner_empty;
    last_bit    = accept && (cnt_q == CNT_W'(K - 1));
  end

  // Next-state logic: grant at frame boundaries only, count accepted reads.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    prio_d        = prio_q;
    cnt_d         = cnt_q;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable && (!bus.fifo0_in_empty || !bus.fifo1_in_empty)) begin
          state_d       = LOCKED;
          frame_start_d = 1'b1;
          // Tie goes to the preferred requester; otherwise the only non-empty one.
          if (!bus.fifo0_in_empty && !bus.fifo1_in_empty) grant_d = prio_q;
          else                                             grant_d = bus.fifo0_in_empty;
        end
      end
      LOCKED: begin
        if (accept) begin
          if (last_bit) begin
            cnt_d   = '0;
            prio_d  = ~grant_q;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      prio_q        <= 1'b0;
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      sel_q         <= 1'b0;
      rd_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      prio_q        <= prio_d;
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= last_bit;
      sel_q         <= grant_q;
      rd_q          <= accept;
    end
  end

  // Combinational handshake paths and registered status outputs.
  always_comb begin
    bus.enc_empty   = ~locked | owner_empty;
    bus.fifo0_in_re = accept & ~grant_q;
    bus.fifo1_in_re = accept & grant_q;
    bus.enc_data    = rd_q & (sel_q ? bus.fifo1_in_data : bus.fifo0_in_data);
    bus.grant       = grant_q;
    bus.busy        = locked;
    bus.frame_start = frame_start_q;
    bus.frame_done  = frame_done_q;
  end

endmodule

// File: tb/tb_bch_frame_arbiter.sv
// Directed bench for bch_frame_arbiter with K=7 and two modelled read-latency-1 FIFOs.
module tb_bch_frame_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  bch_frame_arbiter_if bus ();

  bch_frame_arbiter #(.K(7), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // FIFO models: storage written by the stimulus, read pointer owned by the model.
  logic mem0 [0:255];
  logic mem1 [0:255];
  int   wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  logic d0 = 1'b0, d1 = 1'b0;

  assign bus.fifo0_in_data  = d0;
  assign bus.fifo1_in_data  = d1;
  assign bus.fifo0_in_empty = (wr0 == rd0);
  assign bus.fifo1_in_empty = (wr1 == rd1);

  // Standard-mode FIFO read: dout updates on the clock after rd_en.
  always @(posedge clk) begin
    if (flush) begin
      rd0 <= wr0;
      rd1 <= wr1;
    end else begin
      if (bus.fifo0_in_re) begin
        d0  <= mem0[rd0];
        rd0 <= rd0 + 1;
      end
      if (bus.fifo1_in_re) begin
        d1  <= mem1[rd1];
        rd1 <= rd1 + 1;
      end
    end
  end

  // Monitor: counts handshakes and collects encoder bits, cleared while in reset.
  int          n_acc, n_re0, n_re1, n_start, n_done, n_rx;
  logic [63:0] rx;
  logic [7:0]  glog;
  logic        bad_re1, acc_prev;

  always @(posedge clk) begin
    if (!rst_n) begin
      n_acc <= 0; n_re0 <= 0; n_re1 <= 0; n_start <= 0; n_done <= 0; n_rx <= 0;
      rx <= '0; glog <= '0; bad_re1 <= 1'b0; acc_prev <= 1'b0;
    end else begin
      acc_prev <= bus.enc_re & ~bus.enc_empty;
      if (bus.enc_re & ~bus.enc_empty) n_acc <= n_acc + 1;
      if (bus.fifo0_in_re) n_re0 <= n_re0 + 1;
      if (bus.fifo1_in_re) n_re1 <= n_re1 + 1;
      if (acc_prev) begin
        rx   <= {rx[62:0], bus.enc_data};
        n_rx <= n_rx + 1;
      end
      if (bus.frame_start) begin
        glog    <= {glog[6:0], bus.grant};
        n_start <= n_start + 1;
      end
      if (bus.frame_done) n_done <= n_done + 1;
      if (bus.fifo1_in_re && !bus.grant) bad_re1 <= 1'b1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mem0[wr0] = v[i];
      wr0++;
    end
  endtask

  task automatic push1(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mem1[wr1] = v[i];
      wr1++;
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int c = 0; c < budget && n_done < target; c++) @(negedge clk);
    chk(tag, 32'(n_done), 32'(target));
  endtask

  task automatic wait_acc(input int target, input int budget, input string tag);
    for (int c = 0; c < budget && n_acc < target; c++) @(negedge clk);
    chk(tag, 32'(n_acc), 32'(target));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},     32'(bus.grant),       32'd0);
    chk({tag, "_busy"},      32'(bus.busy),        32'd0);
    chk({tag, "_fstart"},    32'(bus.frame_start), 32'd0);
    chk({tag, "_fdone"},     32'(bus.frame_done),  32'd0);
    chk({tag, "_enc_empty"}, 32'(bus.enc_empty),   32'd1);
    chk({tag, "_enc_data"},  32'(bus.enc_data),    32'd0);
    chk({tag, "_re0"},       32'(bus.fifo0_in_re), 32'd0);
    chk({tag, "_re1"},       32'(bus.fifo1_in_re), 32'd0);
  endtask

  localparam logic [13:0] P0 = 14'b10110011100010;
  localparam logic [13:0] P1 = 14'b01101000111101;
  localparam logic [13:0] P2 = 14'b11100100101100;

  initial begin
    bus.enable = 1'b0;
    bus.enc_re = 1'b1;

    // 1: reset values, then FIFO0 alone supplies two frames.
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    chk_reset_outputs("rst");
    push0(16'(P0), 14);
    bus.enable = 1'b1;
    release_reset();
    wait_done(2, 60, "s1_done");
    chk("s1_starts", 32'(n_start), 32'd2);
    chk("s1_re0",    32'(n_re0),   32'd14);
    chk("s1_re1",    32'(n_re1),   32'd0);
    chk("s1_nbits",  32'(n_rx),    32'd14);
    chk("s1_data",   32'(rx[13:0]), 32'(P0));
    chk("s1_grants", 32'(glog[1:0]), 32'b00);

    // 2: both FIFOs full, grants alternate starting at requester 0.
    enter_reset();
    push0(16'(P0), 14);
    push1(16'(P1), 14);
    release_reset();
    wait_done(4, 100, "s2_done");
    chk("s2_grants", 32'(glog[3:0]), 32'b0101);
    chk("s2_re0",    32'(n_re0),     32'd14);
    chk("s2_re1",    32'(n_re1),     32'd14);
    chk("s2_bad_re1", 32'(bad_re1),  32'd0);
    chk("s2_data",   32'(rx[27:0]),  32'({P0[13:7], P1[13:7], P0[6:0], P1[6:0]}));

    // 3: owner runs dry mid-frame; grant is held until it refills.
    enter_reset();
    push0(16'b101, 3);
    push1(16'b1011010, 7);
    release_reset();
    wait_acc(3, 20, "s3_acc3");
    repeat (4) @(negedge clk);
    chk("s3_grant",     32'(bus.grant),       32'd0);
    chk("s3_busy",      32'(bus.busy),        32'd1);
    chk("s3_enc_empty", 32'(bus.enc_empty),   32'd1);
    chk("s3_re1",       32'(bus.fifo1_in_re), 32'd0);
    chk("s3_stalled",   32'(n_acc),           32'd3);
    push0(16'b0110, 4);
    wait_done(1, 30, "s3_done");
    chk("s3_re0",  32'(n_re0),    32'd7);
    chk("s3_data", 32'(rx[6:0]),  32'b1010110);
    for (int c = 0; c < 20 && n_start < 2; c++) @(negedge clk);
    chk("s3_next_start", 32'(n_start),   32'd2);
    chk("s3_next_grant", 32'(glog[1:0]), 32'b01);

    // 4: ENABLE dropped mid-frame; frame completes, no new grant until re-enabled.
    enter_reset();
    push0(16'(P2), 14);
    release_reset();
    wait_acc(2, 20, "s4_acc2");
    bus.enable = 1'b0;
    wait_done(1, 30, "s4_done");
    chk("s4_acc", 32'(n_acc), 32'd7);
    chk("s4_re0", 32'(n_re0), 32'd7);
    repeat (5) @(negedge clk);
    chk("s4_no_start",  32'(n_start),       32'd1);
    chk("s4_idle_busy", 32'(bus.busy),      32'd0);
    chk("s4_idle_emp",  32'(bus.enc_empty), 32'd1);
    chk("s4_idle_re0",  32'(n_re0),         32'd7);
    bus.enable = 1'b1;
    @(posedge clk);
    #1;
    chk("s4_regrant_busy",  32'(bus.busy),        32'd1);
    chk("s4_regrant_start", 32'(bus.frame_start), 32'd1);
    chk("s4_regrant_grant", 32'(bus.grant),       32'd0);

    // 5: reset mid-frame while FIFO1 owns the encoder.
    enter_reset();
    push1(16'b1100101, 7);
    release_reset();
    wait_acc(4, 20, "s5_acc4");
    chk("s5_owner", 32'(bus.grant), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("s5_rst");
    push0(16'b0011101, 7);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done(1, 30, "s5_done");
    chk("s5_first_grant", 32'(glog[0]),  32'd0);
    chk("s5_re0",         32'(n_re0),    32'd7);
    chk("s5_re1",         32'(n_re1),    32'd0);
    chk("s5_data",        32'(rx[6:0]),  32'b0011101);

    // 6: ENC_RE held high in IDLE and while the owner is empty.
    enter_reset();
    bus.enable = 1'b0;
    push0(16'b10, 2);
    release_reset();
    repeat (4) @(negedge clk);
    chk("s6_idle_re0",  32'(n_re0),         32'd0);
    chk("s6_idle_emp",  32'(bus.enc_empty), 32'd1);
    bus.enable = 1'b1;
    wait_acc(2, 20, "s6_acc2");
    repeat (4) @(negedge clk);
    chk("s6_stall_re0",  32'(n_re0),         32'd2);
    chk("s6_stall_busy", 32'(bus.busy),      32'd1);
    chk("s6_stall_emp",  32'(bus.enc_empty), 32'd1);
    chk("s6_stall_acc",  32'(n_acc),         32'd2);
    push0(16'b01101, 5);
    wait_done(1, 30, "s6_done");
    chk("s6_acc",  32'(n_acc),   32'd7);
    chk("s6_data", 32'(rx[6:0]), 32'b1001101);
    repeat (3) @(negedge clk);
    chk("s6_after_re0", 32'(n_re0), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
